ahb_rr_arbiter: RTL

Parametrised AHB arbiter for N bus masters. It replaces the single-master tie-off arbiter.
- Arbitrates HBUSREQ across NUM_MASTERS using fixed or round-robin priority.
- Honours HLOCK and parks on a default master.
- Drives the one-hot HGRANT vector, the registered HMASTER index and HMASTLOCK.
- Sits between the master VIP agents and the AHB address/control mux in the project testbench.

---
 rtl/ahb_rr_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter for NUM_MASTERS masters with fixed or round-robin priority, HLOCK hold and default-master parking.
// Optional macro AHB_ARB_BURST_HOLD_EN: also hold the grant while HTRANS is SEQ or BUSY.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int RR_MODE        = 1,
    localparam int MASTER_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_W-1:0]    HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_W-1:0]    DEFAULT_IDX   = MASTER_W'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant;
    logic [MASTER_W-1:0]    master_idx;
    logic                   mastlock;
    logic [MASTER_W-1:0]    owner;
    logic [MASTER_W-1:0]    rr_ptr;

    logic [MASTER_W-1:0]    winner;
    logic                   found;
    logic [MASTER_W-1:0]    grant_idx;
    logic                   hold;
    int                     idx;

    // Round-robin search starts just after rr_ptr, so the last winner is checked last.
    always_comb begin
        winner = DEFAULT_IDX;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (RR_MODE != 0) begin
                idx = (int'(rr_ptr) + 1 + i) % NUM_MASTERS;
            end else begin
                idx = i;
            end
            if (!found && HBUSREQ[idx]) begin
                found  = 1'b1;
                winner = MASTER_W'(idx);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | MASTER_W'(i);
            end
        end
    end

`ifdef AHB_ARB_BURST_HOLD_EN
    always_comb begin
        hold = (HLOCK[owner] && HBUSREQ[owner]) || (HTRANS == 2'b11) || (HTRANS == 2'b01);
    end
`else
    logic unused_trans;
    assign unused_trans = ^HTRANS;

    always_comb begin
        hold = HLOCK[owner] && HBUSREQ[owner];
    end
`endif

    // Address-phase ownership trails the grant by one HREADY-high edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant      <= DEFAULT_GRANT;
            master_idx <= DEFAULT_IDX;
            mastlock   <= 1'b0;
            owner      <= DEFAULT_IDX;
            rr_ptr     <= DEFAULT_IDX;
        end else if (HREADY) begin
            master_idx <= grant_idx;
            mastlock   <= HLOCK[grant_idx];
            if (!hold) begin
                grant <= NUM_MASTERS'(1) << winner;
                owner <= winner;
                if (found) begin
                    rr_ptr <= winner;
                end
            end
        end
    end

    assign HGRANT    = grant;
    assign HMASTER   = master_idx;
    assign HMASTLOCK = mastlock;

endmodule
